// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared definitions for the MEM-stage access unit: access-size
//            encoding, FSM state type, position of the unsigned-load bit in
//            the instruction word, and the alignment check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // Access size encoding shared by MemRead/MemWrite
  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_B    = 2'd1;
  localparam logic [1:0] SZ_H    = 2'd2;
  localparam logic [1:0] SZ_W    = 2'd3;

  // funct3[2] of a load: set means zero-extend
  localparam int unsigned FUNCT3_UNSIGNED_BIT = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    return ((size == SZ_H) && offset[0]) ||
           ((size == SZ_W) && (offset != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : load_formatter
// Purpose  : Combinational load-data formatting: picks the byte/half lane out
//            of the memory word and sign- or zero-extends it to 32 bits.
// Ports    : rdata_i    - raw 32-bit word from data memory
//            offset_i   - byte address bits [1:0]
//            size_i     - access size (SZ_B/SZ_H/SZ_W)
//            unsigned_i - 1 = zero-extend, 0 = sign-extend
//            data_o     - formatted 32-bit load result
// Revision : 1.0 - initial release
// ============================================================================
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] lane_w;

  // Shift the addressed byte down to bit 0; halfwords are always at an even
  // offset, so the same byte shift lines them up too.
  assign lane_w = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_B: data_o = unsigned_i ? {24'd0, lane_w[7:0]}
                                : {{24{lane_w[7]}}, lane_w[7:0]};
      SZ_H: data_o = unsigned_i ? {16'd0, lane_w[15:0]}
                                : {{16{lane_w[15]}}, lane_w[15:0]};
      SZ_W: data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage data-memory access unit. Converts MemRead/MemWrite and
//            the ALU address into a req/ack data-memory transaction, stalls
//            the pipeline while it is outstanding, formats load data, and
//            flags misaligned accesses and bus timeouts.
// Ports    : clk, rst (sync, active-low)
//            MemRead_in/MemWrite_in/inst_in/alures_in/rs2_data_in - EX/MEM
//            stall_out                        - hold upstream stages
//            mem_rdata_out/mem_rdata_valid    - load result to MEM/WB
//            misalign_err/bus_err             - one-cycle error pulses
//            dmem_req/we/addr/be/wdata/rdata/ack - data-memory port
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255  // REQ cycles before abort, 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemRead_in,
  input  logic [1:0]  MemWrite_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] rs2_data_in,
  output logic        stall_out,
  output logic [31:0] mem_rdata_out,
  output logic        mem_rdata_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  // Value of the REQ-cycle counter during the last permitted REQ cycle
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        we_w;
  logic [1:0]  size_w;
  logic        access_w;
  logic        misaligned_w;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] fmt_w;
  logic        unused_inst_bits;

  // Only funct3[2] of the instruction matters here.
  assign unused_inst_bits = ^{inst_in[31:FUNCT3_UNSIGNED_BIT+1],
                              inst_in[FUNCT3_UNSIGNED_BIT-1:0]};

  // A write takes precedence over a simultaneous read.
  assign we_w         = (MemWrite_in != SZ_NONE);
  assign size_w       = we_w ? MemWrite_in : MemRead_in;
  assign access_w     = (size_w != SZ_NONE);
  assign misaligned_w = is_misaligned(size_w, alures_in[1:0]);

  // Store lane placement
  always_comb begin
    be_w    = 4'b0000;
    wdata_w = '0;
    case (size_w)
      SZ_B: begin
        be_w    = 4'b0001 << alures_in[1:0];
        wdata_w = {4{rs2_data_in[7:0]}};
      end
      SZ_H: begin
        be_w    = 4'b0011 << alures_in[1:0];
        wdata_w = {2{rs2_data_in[15:0]}};
      end
      SZ_W: begin
        be_w    = 4'b1111;
        wdata_w = rs2_data_in;
      end
      default: begin
        be_w    = 4'b0000;
        wdata_w = '0;
      end
    endcase
  end

  // Formatting uses the latched address/size so dmem_rdata is the only
  // live input during REQ.
  load_formatter u_load_formatter (
    .rdata_i    (dmem_rdata),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (fmt_w)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_NONE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and status outputs. Status outputs are held low while reset
  // is asserted so the whole port reads zero during reset.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    addr_d          = addr_q;
    off_d           = off_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    uns_d           = uns_q;
    err_d           = err_q;
    rdata_d         = rdata_q;
    stall_out       = 1'b0;
    mem_rdata_valid = 1'b0;
    misalign_err    = 1'b0;
    bus_err         = 1'b0;

    if (rst) begin
      case (state_q)
        IDLE: begin
          if (access_w) begin
            if (misaligned_w) begin
              misalign_err = 1'b1;
            end else begin
              stall_out = 1'b1;
              we_d      = we_w;
              addr_d    = alures_in[31:2];
              off_d     = alures_in[1:0];
              be_d      = be_w;
              wdata_d   = wdata_w;
              size_d    = size_w;
              uns_d     = inst_in[FUNCT3_UNSIGNED_BIT];
              err_d     = 1'b0;
              rdata_d   = '0;
              cnt_d     = '0;
              state_d   = REQ;
            end
          end
        end

        REQ: begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          // Ack is checked first so an ack on the final cycle still completes.
          if (dmem_ack) begin
            rdata_d = we_q ? 32'd0 : fmt_w;
            cnt_d   = '0;
            state_d = DONE;
          end else if (cnt_q == c_cnt_last) begin
            err_d   = 1'b1;
            rdata_d = '0;
            cnt_d   = '0;
            state_d = DONE;
          end
        end

        DONE: begin
          mem_rdata_valid = !we_q;
          bus_err         = err_q;
          state_d         = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign dmem_req      = (state_q == REQ);
  assign dmem_we       = we_q;
  assign dmem_addr     = {addr_q, 2'b00};
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign mem_rdata_out = (rst && (state_q == DONE)) ? rdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit: directed vector table,
//            reset/late-ack sequence, and randomized accesses checked against
//            a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MemRead_in;
  logic [1:0]  MemWrite_in;
  logic [31:0] inst_in;
  logic [31:0] alures_in;
  logic [31:0] rs2_data_in;
  logic        stall_out;
  logic [31:0] mem_rdata_out;
  logic        mem_rdata_valid;
  logic        misalign_err;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .MemRead_in      (MemRead_in),
    .MemWrite_in     (MemWrite_in),
    .inst_in         (inst_in),
    .alures_in       (alures_in),
    .rs2_data_in     (rs2_data_in),
    .stall_out       (stall_out),
    .mem_rdata_out   (mem_rdata_out),
    .mem_rdata_valid (mem_rdata_valid),
    .misalign_err    (misalign_err),
    .bus_err         (bus_err),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [63:0] v;
    int bits;
    bits = 8 * nbytes(sz);
    v = 64'(rdata >> (8 * int'(off)));
    if (bits < 32) begin
      v = v & ((64'd1 << bits) - 64'd1);
      if (!uns && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    int m;
    m = ((1 << nbytes(sz)) - 1) << int'(off);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] rs2);
    logic [31:0] w;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic clear_inputs();
    MemRead_in  = 2'd0;
    MemWrite_in = 2'd0;
    inst_in     = 32'h0000_0013;
    alures_in   = 32'd0;
    rs2_data_in = 32'd0;
  endtask

  // Runs one access from the detect cycle through DONE. Called and returns
  // just after a rising edge.
  task automatic run_access(input string nm, input logic [1:0] rd, input logic [1:0] wr,
                            input logic uns, input logic [31:0] addr, input logic [31:0] rs2,
                            input int ack_after, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic exp_mis,
                            input logic exp_berr);
    logic is_wr;
    logic ack_ok;
    int   nreq;
    is_wr  = (wr != 2'd0);
    ack_ok = (ack_after >= 0) && (ack_after < TMO);
    nreq   = ack_ok ? ack_after + 1 : TMO;

    MemRead_in  = rd;
    MemWrite_in = wr;
    inst_in     = uns ? 32'h0000_4003 : 32'h0000_0003;
    alures_in   = addr;
    rs2_data_in = rs2;
    dmem_ack    = 1'b0;
    @(negedge clk);
    chk({nm, ".det.misalign"}, 32'(misalign_err), 32'(exp_mis));
    chk({nm, ".det.stall"}, 32'(stall_out), 32'(!exp_mis));
    chk({nm, ".det.req"}, 32'(dmem_req), 32'd0);
    @(posedge clk); #1;

    if (exp_mis) begin
      clear_inputs();
      @(negedge clk);
      chk({nm, ".after_mis.req"}, 32'(dmem_req), 32'd0);
      chk({nm, ".after_mis.stall"}, 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      return;
    end

    for (int k = 0; k < nreq; k++) begin
      dmem_ack   = (k == ack_after);
      dmem_rdata = (k == ack_after) ? rdata : $urandom;
      @(negedge clk);
      chk($sformatf("%s.req%0d.req", nm, k), 32'(dmem_req), 32'd1);
      chk($sformatf("%s.req%0d.stall", nm, k), 32'(stall_out), 32'd1);
      chk($sformatf("%s.req%0d.we", nm, k), 32'(dmem_we), 32'(is_wr));
      chk($sformatf("%s.req%0d.addr", nm, k), dmem_addr, addr & 32'hFFFF_FFFC);
      if (is_wr) begin
        chk($sformatf("%s.req%0d.be", nm, k), 32'(dmem_be), 32'(exp_be));
        chk($sformatf("%s.req%0d.wdata", nm, k), dmem_wdata, exp_wdata);
      end
      @(posedge clk); #1;
    end

    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    @(negedge clk);
    chk({nm, ".done.req"}, 32'(dmem_req), 32'd0);
    chk({nm, ".done.stall"}, 32'(stall_out), 32'd0);
    chk({nm, ".done.valid"}, 32'(mem_rdata_valid), 32'(!is_wr));
    chk({nm, ".done.data"}, mem_rdata_out, exp_data);
    chk({nm, ".done.bus_err"}, 32'(bus_err), 32'(exp_berr));
    @(posedge clk); #1;
    clear_inputs();
  endtask

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rs2;
    int          ack_after;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_berr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // rd, wr, uns, addr, rs2, ack_after, rdata, exp_data, exp_be, exp_wdata, mis, berr
    tbl[0]  = '{2'd3, 2'd0, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80000000, 32'hFFFFFF80, 4'h0, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{2'd1, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80000000, 32'h00000080, 4'h0, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{2'd0, 2'd2, 1'b0, 32'h102, 32'h1234ABCD, 1, 32'h0, 32'h0, 4'b1100, 32'hABCDABCD, 1'b0, 1'b0};
    tbl[4]  = '{2'd3, 2'd0, 1'b0, 32'h101, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0};
    tbl[5]  = '{2'd3, 2'd0, 1'b0, 32'h200, 32'h0, -1, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1};
    tbl[6]  = '{2'd3, 2'd0, 1'b0, 32'h204, 32'h0, 3, 32'h12345678, 32'h12345678, 4'h0, 32'h0, 1'b0, 1'b0};
    tbl[7]  = '{2'd2, 2'd0, 1'b0, 32'h102, 32'h0, 0, 32'h80010000, 32'hFFFF8001, 4'h0, 32'h0, 1'b0, 1'b0};
    tbl[8]  = '{2'd2, 2'd0, 1'b1, 32'h102, 32'h0, 1, 32'h80010000, 32'h00008001, 4'h0, 32'h0, 1'b0, 1'b0};
    tbl[9]  = '{2'd0, 2'd1, 1'b0, 32'h101, 32'h000000A5, 0, 32'h0, 32'h0, 4'b0010, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[10] = '{2'd0, 2'd3, 1'b0, 32'h104, 32'hCAFEF00D, 0, 32'h0, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0};
    tbl[11] = '{2'd0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0};
    tbl[12] = '{2'd3, 2'd1, 1'b0, 32'h103, 32'h00000011, 0, 32'hFFFFFFFF, 32'h0, 4'b1000, 32'h11111111, 1'b0, 1'b0};
    tbl[13] = '{2'd0, 2'd3, 1'b0, 32'h108, 32'h55AA55AA, -1, 32'h0, 32'h0, 4'b1111, 32'h55AA55AA, 1'b0, 1'b1};
    tbl[14] = '{2'd1, 2'd0, 1'b0, 32'h100, 32'h0, 0, 32'h0000007F, 32'h0000007F, 4'h0, 32'h0, 1'b0, 1'b0};

    rst        = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    clear_inputs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.stall", 32'(stall_out), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.data", mem_rdata_out, 32'd0);
    chk("rst.valid", 32'(mem_rdata_valid), 32'd0);
    chk("rst.misalign", 32'(misalign_err), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      run_access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].uns, tbl[i].addr,
                 tbl[i].rs2, tbl[i].ack_after, tbl[i].rdata, tbl[i].exp_data,
                 tbl[i].exp_be, tbl[i].exp_wdata, tbl[i].exp_mis, tbl[i].exp_berr);
    end

    // Non-memory instructions pass with no stall
    for (int i = 0; i < 3; i++) begin
      alures_in   = $urandom;
      rs2_data_in = $urandom;
      @(negedge clk);
      chk($sformatf("nomem%0d.stall", i), 32'(stall_out), 32'd0);
      chk($sformatf("nomem%0d.req", i), 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
    end
    clear_inputs();

    // Reset in the middle of a REQ, then a stray ack in IDLE
    MemRead_in = 2'd3;
    alures_in  = 32'h300;
    @(negedge clk);
    chk("midrst.det.stall", 32'(stall_out), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.req_before", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rst        = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("midrst.req", 32'(dmem_req), 32'd0);
    chk("midrst.stall", 32'(stall_out), 32'd0);
    chk("midrst.addr", dmem_addr, 32'd0);
    chk("midrst.valid", 32'(mem_rdata_valid), 32'd0);
    chk("midrst.data", mem_rdata_out, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("lateack.req", 32'(dmem_req), 32'd0);
    chk("lateack.valid", 32'(mem_rdata_valid), 32'd0);
    chk("lateack.bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    run_access("postrst", 2'd3, 2'd0, 1'b0, 32'h304, 32'h0, 1, 32'hA5A50F0F, 32'hA5A50F0F,
               4'h0, 32'h0, 1'b0, 1'b0);

    // Randomized accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rd, wr, sz;
      logic        uns, mis, ack_ok;
      logic [31:0] addr, rs2, rdata, ed;
      int          aa;
      rd    = 2'($urandom_range(0, 3));
      wr    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      uns   = 1'($urandom_range(0, 1));
      addr  = $urandom;
      rs2   = $urandom;
      rdata = $urandom;
      aa    = int'($urandom_range(0, 6));
      if (aa == 6) aa = -1;
      sz    = (wr != 2'd0) ? wr : rd;
      if (sz == 2'd0) begin
        MemRead_in  = 2'd0;
        MemWrite_in = 2'd0;
        alures_in   = addr;
        @(negedge clk);
        chk($sformatf("rnd%0d.nomem.stall", i), 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        continue;
      end
      mis    = (sz == 2'd2 && addr[0]) || (sz == 2'd3 && addr[1:0] != 2'd0);
      ack_ok = (aa >= 0) && (aa < TMO);
      ed     = (wr != 2'd0 || !ack_ok) ? 32'd0 : model_load(rdata, addr[1:0], sz, uns);
      run_access($sformatf("rnd%0d", i), rd, wr, uns, addr, rs2, aa, rdata, ed,
                 model_be(sz, addr[1:0]), model_wdata(sz, rs2), mis, !ack_ok && !mis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs: turns MemRead/MemWrite plus ALU address into a req/ack transaction on the data-memory port.
- Holds the pipeline (stall) while a transaction is outstanding.
- Formats load data (byte/half/word, signed/unsigned) for the MEM/WB register.
- Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, REQ-state cycles without dmem_ack before the access is aborted with bus_err; counter is 8 bits wide, legal range 1..255.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
MemRead_in  input  2  from EX/MEM: 0 none, 1 byte, 2 half, 3 word
MemWrite_in  input  2  from EX/MEM: same encoding
inst_in  input  32  from EX/MEM; bit 14 (funct3[2]) set = unsigned load
alures_in  input  32  byte address
rs2_data_in  input  32  store data, already forwarded
stall_out  output  1  hold EX/MEM and upstream stages
mem_rdata_out  output  32  formatted load result to MEM/WB
mem_rdata_valid  output  1  mem_rdata_out valid this cycle
misalign_err  output  1  one-cycle pulse on a misaligned access
bus_err  output  1  one-cycle pulse on a timeout
dmem_req  output  1  request to data memory
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address, alures_in with bits [1:0] zeroed
dmem_be  output  4  byte enables
dmem_wdata  output  32  store data shifted into lane
dmem_rdata  input  32  read word, valid with ack
dmem_ack  input  1  transaction complete

Behaviour:
- Access condition: access = (MemRead_in != 0) or (MemWrite_in != 0). If both are nonzero, the write wins and the read is ignored.
- Misalignment: an access is misaligned if it is a half with addr[0]=1, or a word with addr[1:0] != 0.
- State IDLE:
  - No access: stall_out=0.
  - Misaligned access: misalign_err=1 this cycle, no request, stall_out=0, stay in IDLE.
  - Aligned access: stall_out=1 combinationally; latch addr, we, be, wdata, size and sign; go to REQ.
- State REQ:
  - dmem_req=1, stall_out=1; all dmem_* outputs are stable from registers.
  - Cycle counter increments each REQ cycle.
  - On dmem_ack: latch formatted data (0 for writes); go to DONE.
  - Counter reaches TIMEOUT without ack: drop req, set the error flag, data=0, go to DONE.
  - Ack in the same cycle as the timeout: ack wins.
- State DONE:
  - stall_out=0; mem_rdata_valid=1 for loads only.
  - bus_err=1 if the error flag is set.
  - MEM/WB captures at the end of this cycle. Next state is IDLE.
- Minimum latency: 3 cycles per access (detect, REQ with immediate ack, DONE). Non-memory instructions pass with zero stall.
- Byte enables and write data:
  - Byte: be = 0001 shifted left by addr[1:0], wdata = {4{rs2[7:0]}}.
  - Half: be = 0011 shifted left by addr[1:0], wdata = {2{rs2[15:0]}}.
  - Word: be = 1111, wdata = rs2.
- Load formatting: select the lane by addr[1:0]. Sign-extend when inst[14]=0, zero-extend when inst[14]=1.
- Flush handling: there is no flush input. The pipeline zeroes EX/MEM controls on flush, so IDLE sees no access. An in-flight REQ is never abandoned except by timeout, because writes must complete.
- Reset (rst=0 at a rising edge), including mid-transaction:
  - Go to IDLE; counter=0.
  - dmem_req=0 from the next cycle.
  - All outputs 0: stall_out, mem_rdata_out, mem_rdata_valid, both error pulses, dmem_we, dmem_addr, dmem_be, dmem_wdata.
  - A late ack after reset is ignored in IDLE.

Decomposition:
- Shared package holds:
  - Size encoding constants: SZ_NONE=0, SZ_B=1, SZ_H=2, SZ_W=3.
  - FSM state enum: IDLE, REQ, DONE.
  - FUNCT3_UNSIGNED_BIT=14.
- One sub-module, load_formatter: combinational lane select and extend (rdata, addr[1:0], size, unsigned -> 32-bit result).
- Store-lane generation stays inline.

Test Plan:
- Load word at 0x100, ack 2 cycles after req, rdata=0xDEADBEEF -> stall high 4 cycles, then DONE with mem_rdata_out=0xDEADBEEF, valid=1.
- LB at 0x103 (inst[14]=0), rdata=0x80000000 -> mem_rdata_out=0xFFFFFF80. Same access as LBU (inst[14]=1) -> 0x00000080.
- SH at 0x102, rs2=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x100, dmem_we=1; mem_rdata_valid=0 in DONE.
- LW at 0x101 -> misalign_err pulse, dmem_req never rises, stall_out stays 0.
- TIMEOUT=4, no ack -> req drops after 4 REQ cycles, bus_err=1 in DONE, data=0. Variant with ack on the 4th REQ cycle -> normal completion, no bus_err.
- rst low during REQ -> next cycle dmem_req=0, stall_out=0, state IDLE; a following access runs normally.
